// File: rtl/sequenciador_notas_if.sv
// Control, programming and note-output bundle between the user controls,
// the melody sequencer and the 7-segment note decoder.
interface sequenciador_notas_if #(
  parameter int AW = 3
);
  logic          start;
  logic          stop;
  logic          pausa;
  logic          loop;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          Tom;
  logic          notas1;
  logic          notas2;
  logic          notas3;
  logic          nota_valida;
  logic [AW-1:0] passo;
  logic          ocupado;
  logic          fim;

  modport master (
    output start, stop, pausa, loop, wr_en, wr_addr, wr_data,
    input  Tom, notas1, notas2, notas3, nota_valida, passo, ocupado, fim
  );

  modport slave (
    input  start, stop, pausa, loop, wr_en, wr_addr, wr_data,
    output Tom, notas1, notas2, notas3, nota_valida, passo, ocupado, fim
  );
endinterface

// File: rtl/sequenciador_notas.sv
// Melody sequencer: plays {Tom, notas3..1, dur} entries from a small memory,
// each note held for dur * TICK_DIV clock cycles.
//
// state   | meaning
// S_IDLE  | no note presented, memory writable
// S_PLAY  | note presented, prescaler and duration counter running
// S_PAUSE | note presented, prescaler and counter frozen
module sequenciador_notas #(
  parameter int TICK_DIV = 4,
  parameter int SEQ_LEN  = 8
) (
  input  logic clock,
  input  logic reset,
  sequenciador_notas_if.slave bus
);
  localparam int AW = $clog2(SEQ_LEN);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(SEQ_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [SEQ_LEN];
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_passo, w_passo_nxt;
  logic [3:0]    r_nota, w_nota_nxt;   // {Tom, notas3, notas2, notas1}
  logic          r_valida, w_valida_nxt;
  logic          r_fim, w_fim_nxt;

  logic [AW-1:0] w_idx_n;
  logic [7:0]    w_entry0;
  logic [7:0]    w_entry_n;
  logic          w_tick;
  logic          w_end;

  assign w_idx_n   = r_passo + AW'(1);
  assign w_entry0  = r_mem[0];
  assign w_entry_n = r_mem[w_idx_n];
  assign w_tick    = (r_presc == PRESC_MAX);
  // End of sequence: ran off the memory, or the following entry is a terminator.
  assign w_end     = (r_passo == LAST_IDX) || (w_entry_n[3:0] == 4'd0);

  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_cnt_nxt    = r_cnt;
    w_passo_nxt  = r_passo;
    w_nota_nxt   = r_nota;
    w_valida_nxt = r_valida;
    w_fim_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (w_entry0[3:0] == 4'd0) begin
            w_fim_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_PLAY;
            w_passo_nxt  = '0;
            w_nota_nxt   = w_entry0[7:4];
            w_valida_nxt = 1'b1;
            w_cnt_nxt    = w_entry0[3:0];
            w_presc_nxt  = '0;
          end
        end
      end
      S_PLAY: begin
        if (bus.stop) begin
          w_state_nxt  = S_IDLE;
          w_passo_nxt  = '0;
          w_nota_nxt   = '0;
          w_valida_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_presc_nxt  = '0;
        end else if (bus.pausa) begin
          w_state_nxt = S_PAUSE;
        end else if (w_tick) begin
          w_presc_nxt = '0;
          if (r_cnt > 4'd1) begin
            w_cnt_nxt = r_cnt - 4'd1;
          end else if (!w_end) begin
            w_passo_nxt = w_idx_n;
            w_nota_nxt  = w_entry_n[7:4];
            w_cnt_nxt   = w_entry_n[3:0];
          end else if (bus.loop && (w_entry0[3:0] != 4'd0)) begin
            w_passo_nxt = '0;
            w_nota_nxt  = w_entry0[7:4];
            w_cnt_nxt   = w_entry0[3:0];
          end else begin
            w_state_nxt  = S_IDLE;
            w_passo_nxt  = '0;
            w_nota_nxt   = '0;
            w_valida_nxt = 1'b0;
            w_cnt_nxt    = '0;
            w_fim_nxt    = 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      S_PAUSE: begin
        if (bus.stop) begin
          w_state_nxt  = S_IDLE;
          w_passo_nxt  = '0;
          w_nota_nxt   = '0;
          w_valida_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_presc_nxt  = '0;
        end else if (!bus.pausa) begin
          w_state_nxt = S_PLAY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_cnt    <= '0;
      r_passo  <= '0;
      r_nota   <= '0;
      r_valida <= 1'b0;
      r_fim    <= 1'b0;
      for (int i = 0; i < SEQ_LEN; i++) r_mem[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_passo  <= w_passo_nxt;
      r_nota   <= w_nota_nxt;
      r_valida <= w_valida_nxt;
      r_fim    <= w_fim_nxt;
      if (bus.wr_en && (r_state == S_IDLE)) r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.Tom         = r_nota[3];
  assign bus.notas3      = r_nota[2];
  assign bus.notas2      = r_nota[1];
  assign bus.notas1      = r_nota[0];
  assign bus.nota_valida = r_valida;
  assign bus.passo       = r_passo;
  assign bus.ocupado     = (r_state != S_IDLE);
  assign bus.fim         = r_fim;
endmodule

// File: tb/tb_sequenciador_notas.sv
// Scoreboard bench for sequenciador_notas: each scenario queues the expected
// per-cycle output vector, then every clock pops and compares one entry.
module tb_sequenciador_notas;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  sequenciador_notas_if #(.AW(3)) bus_if ();

  sequenciador_notas #(.TICK_DIV(4), .SEQ_LEN(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // Output vector: {fim, ocupado, nota_valida, passo[2:0], Tom, notas3, notas2, notas1}
  localparam logic [9:0] V_ZERO = 10'b0;
  localparam logic [9:0] V_FIM  = {1'b1, 1'b0, 1'b0, 3'd0, 4'b0000};
  localparam logic [9:0] V_E0   = {1'b0, 1'b1, 1'b1, 3'd0, 4'b1001};
  localparam logic [9:0] V_E1   = {1'b0, 1'b1, 1'b1, 3'd1, 4'b0011};

  logic [9:0] exp_q [$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_step   = 0;
  string      cur_tag  = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] observed();
    return {bus_if.fim, bus_if.ocupado, bus_if.nota_valida, bus_if.passo,
            bus_if.Tom, bus_if.notas3, bus_if.notas2, bus_if.notas1};
  endfunction

  task automatic push_n(input logic [9:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic step();
    logic [9:0] e;
    @(posedge clock);
    #1;
    n_step++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("%s@%0d", cur_tag, n_step), {22'd0, observed()}, {22'd0, e});
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = a;
    bus_if.wr_data = d;
    @(posedge clock);
    #1;
    bus_if.wr_en = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset          = 1'b1;
    bus_if.start   = 1'b0;
    bus_if.stop    = 1'b0;
    bus_if.pausa   = 1'b0;
    bus_if.loop    = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.wr_addr = '0;
    bus_if.wr_data = '0;

    // Reset hold, then start with an empty memory gives a lone fim pulse
    cur_tag = "reset";
    push_n(V_ZERO, 2);
    steps(2);
    reset = 1'b0;
    cur_tag = "empty_start";
    push_n(V_FIM, 1);
    push_n(V_ZERO, 2);
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    steps(2);
    drain_check("empty_start");

    do_write(3'd0, 8'h92);
    do_write(3'd1, 8'h31);
    do_write(3'd2, 8'h00);

    cur_tag = "basic";
    push_n(V_E0, 8); push_n(V_E1, 4); push_n(V_FIM, 1); push_n(V_ZERO, 1);
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    steps(13);
    drain_check("basic");

    // Loop back to entry 0, then drop loop during the second pass of entry 1
    cur_tag = "loop";
    push_n(V_E0, 8); push_n(V_E1, 4); push_n(V_E0, 8); push_n(V_E1, 4);
    push_n(V_FIM, 1); push_n(V_ZERO, 1);
    bus_if.loop  = 1'b1;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    steps(20);
    bus_if.loop = 1'b0;
    steps(13);
    drain_check("loop");

    // Pause for 10 cycles during entry 0; 8 active cycles plus frozen time
    cur_tag = "pause";
    push_n(V_E0, 19); push_n(V_E1, 4); push_n(V_FIM, 1); push_n(V_ZERO, 1);
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    steps(2);
    bus_if.pausa = 1'b1;
    steps(10);
    bus_if.pausa = 1'b0;
    steps(12);
    drain_check("pause");

    cur_tag = "stop";
    push_n(V_E0, 8); push_n(V_E1, 2); push_n(V_ZERO, 2);
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    steps(9);
    bus_if.stop = 1'b1;
    step();
    bus_if.stop = 1'b0;
    step();
    drain_check("stop");

    // Writes and start during PLAY must be ignored; second run replays 0x92/0x31
    cur_tag = "wprot";
    push_n(V_E0, 8); push_n(V_E1, 4); push_n(V_FIM, 1); push_n(V_ZERO, 1);
    push_n(V_E0, 8); push_n(V_E1, 4); push_n(V_FIM, 1); push_n(V_ZERO, 1);
    bus_if.start = 1'b1;
    step();
    bus_if.start   = 1'b0;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = 3'd0;
    bus_if.wr_data = 8'h00;
    step();
    bus_if.wr_addr = 3'd2;
    bus_if.wr_data = 8'h11;
    bus_if.start   = 1'b1;
    step();
    bus_if.wr_en = 1'b0;
    bus_if.start = 1'b0;
    steps(11);
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    steps(13);
    drain_check("wprot");

    cur_tag = "start_stop";
    push_n(V_ZERO, 2);
    bus_if.start = 1'b1;
    bus_if.stop  = 1'b1;
    step();
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    step();
    drain_check("start_stop");

    // Reset while paused clears outputs and memory
    cur_tag = "reset_pause";
    push_n(V_E0, 4); push_n(V_ZERO, 2); push_n(V_FIM, 1); push_n(V_ZERO, 1);
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    step();
    bus_if.pausa = 1'b1;
    steps(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_if.pausa = 1'b0;
    step();
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    step();
    drain_check("reset_pause");

    // All eight entries used: end is reached by running off the memory
    cur_tag = "full";
    for (int i = 0; i < 8; i++) do_write(3'(i), {4'(i), 4'd1});
    for (int i = 0; i < 8; i++) push_n({1'b0, 1'b1, 1'b1, 3'(i), 4'(i)}, 4);
    push_n(V_FIM, 1); push_n(V_ZERO, 1);
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    steps(33);
    drain_check("full");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
